// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC transmit-side frame scheduler.
package hdlc_pkg;

   localparam int HDLC_BYTE_W = 8;
   localparam int DONE_SRC_W  = 2;
   localparam int SCHED_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_XFER     = 2'd1,
      ST_WAIT_FIN = 2'd2,
      ST_GAP      = 2'd3
   } sched_state_e;

   // Width of a source index: clog2 of the source count, never below one bit.
   function automatic int src_idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap, one-hot out.
module rr_arbiter
   import hdlc_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt
);

   logic [2*N-1:0] req_rot;
   logic [N-1:0]   req_low;
   logic [N-1:0]   first;
   logic [2*N-1:0] gnt_rot;

   // Rotate so ptr lands on bit 0, isolate the lowest set bit, then rotate back.
   always_comb begin
      req_rot = {req, req} >> ptr;
      req_low = req_rot[N-1:0];
      first   = req_low & ~(req_low - N'(1));
      gnt_rot = {first, first} << ptr;
      gnt     = gnt_rot[2*N-1:N];
   end

endmodule

// File: rtl/hdlc_tx_sched.sv
// Round-robin frame scheduler in front of the HDLC transmitter: one whole frame per grant,
// then wait for data_finish (or a timeout) plus an inter-frame gap before re-arbitrating.
module hdlc_tx_sched
   import hdlc_pkg::*;
#(
   parameter int N_SRC       = 2,
   parameter int GAP_CYCLES  = 16,
   parameter int FIN_TIMEOUT = 65535
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [N_SRC-1:0]             s_tvalid,
   output logic [N_SRC-1:0]             s_tready,
   input  logic [N_SRC-1:0]             s_tlast,
   input  logic [HDLC_BYTE_W*N_SRC-1:0] s_tdata,
   output logic                         m_tvalid,
   input  logic                         m_tready,
   output logic                         m_tlast,
   output logic [HDLC_BYTE_W-1:0]       m_tdata,
   input  logic                         tx_finish,
   output logic [N_SRC-1:0]             grant,
   output logic                         busy,
   output logic                         frame_done,
   output logic [DONE_SRC_W-1:0]        done_src,
   output logic                         underrun,
   output logic                         fin_abort
);

   localparam int                     SRC_W    = src_idx_w(N_SRC);
   localparam logic [SCHED_CNT_W-1:0] FIN_LAST = SCHED_CNT_W'(FIN_TIMEOUT - 1);
   localparam logic [SCHED_CNT_W-1:0] GAP_LAST = SCHED_CNT_W'(GAP_CYCLES - 1);

   sched_state_e           state_q, state_d;
   logic [N_SRC-1:0]       grant_q, grant_d;
   logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [SCHED_CNT_W-1:0] cnt_q, cnt_d;
   logic [DONE_SRC_W-1:0]  done_src_q, done_src_d;
   logic                   frame_done_q, frame_done_d;
   logic                   underrun_q, underrun_d;
   logic                   fin_abort_q, fin_abort_d;
   logic                   vld_prev_q, vld_prev_d;

   logic [N_SRC-1:0]       arb_gnt;
   logic [SRC_W-1:0]       arb_idx;
   logic [SRC_W-1:0]       g_idx;
   logic                   sel_valid;
   logic                   sel_last;
   logic [HDLC_BYTE_W-1:0] sel_data;
   logic                   in_xfer;
   logic                   last_hs;

   rr_arbiter #(
      .N     (N_SRC),
      .PTR_W (SRC_W)
   ) u_arb (
      .req (s_tvalid),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt)
   );

   // One-hot grant drives an AND-OR mux; also encode both one-hot vectors to indices.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      g_idx     = '0;
      arb_idx   = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant_q[i]) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_data  = s_tdata[i*HDLC_BYTE_W +: HDLC_BYTE_W];
            g_idx     = SRC_W'(i);
         end
         if (arb_gnt[i]) begin
            arb_idx = SRC_W'(i);
         end
      end
   end

   always_comb begin
      in_xfer  = (state_q == ST_XFER);
      m_tvalid = in_xfer & sel_valid;
      m_tlast  = in_xfer & sel_last;
      m_tdata  = in_xfer ? sel_data : '0;
      s_tready = in_xfer ? (grant_q & {N_SRC{m_tready}}) : '0;
      last_hs  = m_tvalid & m_tready & m_tlast;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      done_src_d   = done_src_q;
      vld_prev_d   = vld_prev_q;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
      fin_abort_d  = 1'b0;
      cnt_d        = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (|s_tvalid) begin
               state_d    = ST_XFER;
               grant_d    = arb_gnt;
               rr_ptr_d   = (arb_idx == SRC_W'(N_SRC - 1)) ? '0 : arb_idx + SRC_W'(1);
               vld_prev_d = 1'b1;
            end
         end
         ST_XFER: begin
            // The transmitter keeps clocking bits, so a starved source is only flagged.
            vld_prev_d = sel_valid;
            if (vld_prev_q && !sel_valid) begin
               underrun_d = 1'b1;
            end
            if (last_hs) begin
               state_d = ST_WAIT_FIN;
            end
         end
         ST_WAIT_FIN: begin
            if (tx_finish) begin
               state_d      = ST_GAP;
               grant_d      = '0;
               done_src_d   = DONE_SRC_W'(g_idx);
               frame_done_d = 1'b1;
            end else if (cnt_q == FIN_LAST) begin
               state_d     = ST_GAP;
               grant_d     = '0;
               done_src_d  = DONE_SRC_W'(g_idx);
               fin_abort_d = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase

      // Shared timeout/gap counter: restarts on every state entry and saturates.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != '1) begin
         cnt_d = cnt_q + SCHED_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= '0;
         cnt_q        <= '0;
         done_src_q   <= '0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
         fin_abort_q  <= 1'b0;
         vld_prev_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         done_src_q   <= done_src_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
         fin_abort_q  <= fin_abort_d;
         vld_prev_q   <= vld_prev_d;
      end
   end

   assign grant      = grant_q;
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = frame_done_q;
   assign done_src   = done_src_q;
   assign underrun   = underrun_q;
   assign fin_abort  = fin_abort_q;

endmodule

// File: doc/hdlc_tx_sched.md
# hdlc_tx_sched

Frame-level scheduler in front of the HDLC transmitter. It arbitrates between `N_SRC` byte-stream frame sources using round-robin, and grants one whole frame at a time. It forwards the granted stream to the transmitter's tvalid/tready/tlast/tdata port, then holds off the next grant until the transmitter pulses `data_finish` and a programmable inter-frame gap has elapsed. It sits between the PS-side frame FIFOs and the HDLC transmitter.

## Interface
- `N_SRC`, 2: number of requesters, 2..4.
- `GAP_CYCLES`, 16: idle clk cycles between `tx_finish` and the next grant, ≥1.
- `FIN_TIMEOUT`, 65535: max clk cycles in WAIT_FIN before abort, ≥2.
- `clk` in 1: single clock.
- `rstn` in 1: asynchronous, active-low reset.
- `s_tvalid` in N_SRC: per-source frame byte valid.
- `s_tready` out N_SRC: per-source ready. Only the granted bit can be 1.
- `s_tlast` in N_SRC: per-source last byte of frame.
- `s_tdata` in 8*N_SRC: source i occupies bits [8i+7:8i].
- `m_tvalid` out 1: to transmitter `tvalid`.
- `m_tready` in 1: from transmitter `tready`.
- `m_tlast` out 1: to transmitter `tlast`.
- `m_tdata` out 8: to transmitter `tdata`.
- `tx_finish` in 1: transmitter `data_finish` pulse.
- `grant` out N_SRC: one-hot current owner. All zero when no source owns the transmitter.
- `busy` out 1: state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse when the transmitter reports completion of the owned frame.
- `done_src` out 2: index of the last completed or aborted source. Held until the next completion or abort.
- `underrun` out 1: one-cycle pulse when the owned source drops `s_tvalid` in XFER.
- `fin_abort` out 1: one-cycle pulse on FIN_TIMEOUT expiry.

## Operation
- States are IDLE, XFER, WAIT_FIN and GAP.
- **IDLE**
  - If any `s_tvalid` bit is set, choose the first requester searching upward, with wrap, from `rr_ptr`.
  - Register the choice into `grant` and go to XFER.
  - `rr_ptr` resets to 0 and is set to (granted+1) mod N_SRC at each grant.
- **XFER**
  - Data path is combinational from the granted source:
    - `m_tvalid` = `s_tvalid[g]`
    - `m_tlast` = `s_tlast[g]`
    - `m_tdata` = `s_tdata[g]`
    - `s_tready[g]` = `m_tready`
  - All other `s_tready` bits are 0.
  - A handshake (`m_tvalid & m_tready & m_tlast`) moves to WAIT_FIN. `grant` is held.
  - `s_tvalid[g]` falling while `m_tlast` has not been accepted gives an `underrun` pulse. The state stays in XFER, because the transmitter keeps clocking bits.
- **WAIT_FIN**
  - `m_tvalid` and all `s_tready` are 0.
  - `tx_finish` → `frame_done` pulse, `done_src` = g, `grant` cleared, go to GAP.
  - If the cycle counter reaches FIN_TIMEOUT−1 without `tx_finish` → `fin_abort` pulse, `done_src` = g, `grant` cleared, go to GAP. No `frame_done` is issued.
- **GAP**
  - Counts GAP_CYCLES cycles, then goes to IDLE.
  - A `tx_finish` arriving in GAP or IDLE is ignored.
- A single 16-bit counter serves the timeout and the gap. It is cleared on every state entry. It saturates and does not wrap.
- Never re-arbitrate mid-frame.
- A source raising `s_tvalid` while not granted waits with no loss of data, because its `s_tready` is 0.
- Reset mid-frame: all outputs return to their reset values immediately and the state goes to IDLE. The partial frame is the upstream's responsibility.

## Timing
- Reset values:
  - `s_tready`, `m_tvalid`, `m_tlast`, `grant`, `busy`, `frame_done`, `underrun`, `fin_abort` = 0.
  - `m_tdata` = 0x00 and `done_src` = 0.
- Grant latency: `s_tvalid` seen in IDLE at cycle n → `grant` and XFER at n+1. `m_tvalid` is visible in n+1.
- Last handshake at cycle n → WAIT_FIN at n+1, where `m_tvalid` = 0.
- `tx_finish` at cycle n:
  - `frame_done` is registered and high for exactly cycle n+1.
  - The next grant is no earlier than n+1+GAP_CYCLES+1.
- `frame_done`, `underrun` and `fin_abort` are registered pulses, each exactly one cycle wide.
- When several sources are valid in IDLE, the rr_ptr order decides; there is no fixed priority.

## Structure
- Shared package `hdlc_pkg` holds:
  - the state encoding constants;
  - the `HDLC_BYTE_W` = 8 constant;
  - the source-index width function (clog2, min 1, padded to 2 on `done_src`).
- One sub-module, `rr_arbiter`: N-input request vector plus pointer in, one-hot grant out, purely combinational. The FSM registers its output.
- Expected size: about 200 lines of RTL.

## Test plan
- **Single frame from src0:** 8 bytes 0x7E,0x01..0x07 with tlast on the 8th. Expect `m_tdata` to match in order, `grant`=01, WAIT_FIN entered, and the transmitter's `data_finish` giving `frame_done`=1 for 1 cycle with `done_src`=0.
- **Both sources valid continuously:** grants alternate 01,10,01. The gap between `tx_finish` and the next `grant` is exactly GAP_CYCLES+1 cycles.
- **src1 requests mid-frame of src0:** `s_tready[1]` stays 0 until src0's frame is done and the gap has elapsed. Then src1 is granted with its first byte intact.
- **Underrun:** src0 drops `s_tvalid` for 3 cycles after byte 2. Expect `underrun` pulsed once and the state still XFER. The frame completes normally afterwards.
- **Fin timeout:** FIN_TIMEOUT=100 with `tx_finish` held low. Expect `fin_abort` at cycle 100 of WAIT_FIN, no `frame_done`, and `grant` cleared.
- **Reset:** assert `rstn` low during XFER. Expect all outputs at their reset values in the same cycle, and arbitration after release restarting from src0.
